wshb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter sharing the SDRAM Wishbone port between the video reader (m0) and a frame writer (m1), e.g. a pattern generator or camera path.
- Grant is registered; the datapath is combinational muxing selected by the grant.
- Bounded-burst round-robin stops the always-requesting video reader from starving the writer.

---
 rtl/wshb_pkg.sv | 29 ++
 rtl/wshb_arb_fsm.sv | 116 +++++++++++
 rtl/wshb_arbiter.sv | 129 ++++++++++++
 tb/tb_wshb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_pkg.sv
// ============================================================================
//  wshb_pkg : shared types and widths for the Wishbone two-master arbiter
//  Revision : 1.0
// ============================================================================
`default_nettype none

package wshb_pkg;

  localparam int WSHB_AW   = 32;
  localparam int WSHB_DW   = 32;
  localparam int WSHB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      G0:      return 2'b01;
      G1:      return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wshb_arb_fsm.sv
// ============================================================================
//  wshb_arb_fsm : grant state machine with bounded-burst round-robin
//  Optional     : WSHB_ARB_STATS_EN adds a preemption strobe for the counters
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module wshb_arb_fsm
  import wshb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_cyc_i,
  input  logic       m1_cyc_i,
  input  logic       s_ack_i,
  output logic [1:0] grant_o
`ifdef WSHB_ARB_STATS_EN
  ,
  output logic       preempt_o
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  arb_state_t state_q;
  logic [7:0] cnt_q;
  logic       last_q;   // 1: m1 was served last, so m0 wins a tie
  logic [1:0] grant_q;

  logic       own_cyc;
  logic       oth_cyc;
  arb_state_t oth_state;
  logic       burst_done;

  always_comb begin
    own_cyc   = 1'b0;
    oth_cyc   = 1'b0;
    oth_state = IDLE;
    case (state_q)
      G0: begin
        own_cyc   = m0_cyc_i;
        oth_cyc   = m1_cyc_i;
        oth_state = G1;
      end
      G1: begin
        own_cyc   = m1_cyc_i;
        oth_cyc   = m0_cyc_i;
        oth_state = G0;
      end
      default: ;
    endcase
  end

  // Switching only on an ack cycle keeps every transfer whole.
  assign burst_done = s_ack_i && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= G0;
            grant_q <= grant_of(G0);
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= G1;
            grant_q <= grant_of(G1);
            last_q  <= 1'b1;
          end
        end
        G0, G1: begin
          if (!own_cyc) begin
            cnt_q <= '0;
            if (oth_cyc) begin
              state_q <= oth_state;
              grant_q <= grant_of(oth_state);
              last_q  <= (oth_state == G1);
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end else if (burst_done && oth_cyc) begin
            cnt_q   <= '0;
            state_q <= oth_state;
            grant_q <= grant_of(oth_state);
            last_q  <= (oth_state == G1);
          end else if (s_ack_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

`ifdef WSHB_ARB_STATS_EN
  assign preempt_o = own_cyc && burst_done && oth_cyc;
`endif

endmodule

`default_nettype wire

// File: rtl/wshb_arbiter.sv
// ============================================================================
//  wshb_arbiter : two-master / one-slave Wishbone classic arbiter
//  Optional     : WSHB_ARB_STATS_EN adds ack and preemption counters
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module wshb_arbiter
  import wshb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int AW        = WSHB_AW,
  parameter int DW        = WSHB_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [AW-1:0]        m0_adr,
  input  logic [DW-1:0]        m0_dat_ms,
  input  logic [WSHB_SELW-1:0] m0_sel,
  output logic                 m0_ack,
  output logic [DW-1:0]        m0_dat_sm,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [AW-1:0]        m1_adr,
  input  logic [DW-1:0]        m1_dat_ms,
  input  logic [WSHB_SELW-1:0] m1_sel,
  output logic                 m1_ack,
  output logic [DW-1:0]        m1_dat_sm,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW-1:0]        s_dat_ms,
  output logic [WSHB_SELW-1:0] s_sel,
  input  logic                 s_ack,
  input  logic [DW-1:0]        s_dat_sm,
  output logic [1:0]           grant
`ifdef WSHB_ARB_STATS_EN
  ,
  output logic [31:0]          m0_ack_cnt,
  output logic [31:0]          m1_ack_cnt,
  output logic [15:0]          preempt_cnt
`endif
);

`ifdef WSHB_ARB_STATS_EN
  logic preempt;
`endif

  wshb_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .m0_cyc_i  (m0_cyc),
    .m1_cyc_i  (m1_cyc),
    .s_ack_i   (s_ack),
    .grant_o   (grant)
`ifdef WSHB_ARB_STATS_EN
    ,
    .preempt_o (preempt)
`endif
  );

  // Grant is registered, so reset drops s_cyc/s_stb without waiting for a clock.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (grant)
      2'b01: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
      end
      2'b10: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

`ifdef WSHB_ARB_STATS_EN
  logic [31:0] m0_ack_cnt_q;
  logic [31:0] m1_ack_cnt_q;
  logic [15:0] preempt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_ack_cnt_q  <= '0;
      m1_ack_cnt_q  <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (m0_ack)  m0_ack_cnt_q  <= m0_ack_cnt_q + 32'd1;
      if (m1_ack)  m1_ack_cnt_q  <= m1_ack_cnt_q + 32'd1;
      if (preempt) preempt_cnt_q <= preempt_cnt_q + 16'd1;
    end
  end

  assign m0_ack_cnt  = m0_ack_cnt_q;
  assign m1_ack_cnt  = m1_ack_cnt_q;
  assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
// ============================================================================
//  tb_wshb_arbiter : directed and randomized checks of wshb_arbiter
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_wshb_arbiter;

  localparam int MB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_ms, m0_dat_sm;
  logic [3:0]    m0_sel;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_ms, m1_dat_sm;
  logic [3:0]    m1_sel;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_ms, s_dat_sm;
  logic [3:0]    s_sel;
  logic [1:0]    grant;
`ifdef WSHB_ARB_STATS_EN
  logic [31:0]   m0_ack_cnt, m1_ack_cnt;
  logic [15:0]   preempt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: owner -1 = nobody, acks = acks in current tenure.
  int mdl_owner, mdl_acks, mdl_last;
  int e_m0_acks, e_m1_acks, e_pre;

  wshb_arbiter #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .grant(grant)
`ifdef WSHB_ARB_STATS_EN
    , .m0_ack_cnt(m0_ack_cnt), .m1_ack_cnt(m1_ack_cnt), .preempt_cnt(preempt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mdl_owner = -1; mdl_acks = 0; mdl_last = 1;
    e_m0_acks = 0; e_m1_acks = 0; e_pre = 0;
  endtask

  task automatic model_step();
    int own, oth;
    if (mdl_owner < 0) begin
      if (m0_cyc && (!m1_cyc || mdl_last == 1)) begin mdl_owner = 0; mdl_last = 0; end
      else if (m1_cyc) begin mdl_owner = 1; mdl_last = 1; end
      mdl_acks = 0;
    end else begin
      own = (mdl_owner == 0) ? int'(m0_cyc) : int'(m1_cyc);
      oth = (mdl_owner == 0) ? int'(m1_cyc) : int'(m0_cyc);
      if (s_ack) begin
        if (mdl_owner == 0) e_m0_acks++; else e_m1_acks++;
      end
      if (own == 0) begin
        mdl_acks = 0;
        if (oth != 0) begin mdl_owner = 1 - mdl_owner; mdl_last = mdl_owner; end
        else mdl_owner = -1;
      end else if (s_ack) begin
        mdl_acks++;
        if (mdl_acks >= MB && oth != 0) begin
          mdl_owner = 1 - mdl_owner; mdl_last = mdl_owner; mdl_acks = 0; e_pre++;
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_grant();
    return (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
    s_ack = 0; s_dat_sm = '0;
  endtask

  task automatic test_reset();
    idle_all(); model_reset();
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_scyc: got %b want 0", s_cyc); end
    rst = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL req_latency: got %b want 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01 || s_cyc !== 1'b1) begin errors++; $display("FAIL first_grant: grant=%b s_cyc=%b want 01/1", grant, s_cyc); end
    #2 rst = 1; #1;
    model_reset();
    checks++; if (s_cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL async_reset: s_cyc=%b grant=%b want 0/00", s_cyc, grant); end
    @(negedge clk); rst = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL post_reset: got %b want 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL regrant: got %b want 01", grant); end
  endtask

  task automatic test_single_master();
    idle_all(); tick(); tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
    tick();
    for (int i = 0; i < 8; i++) begin
      m1_adr = 32'(4 * i); m1_dat_ms = $urandom; s_ack = 1; #1;
      checks++; if (s_adr !== 32'(4 * i)) begin errors++; $display("FAIL single_adr[%0d]: got %0h want %0h", i, s_adr, 4 * i); end
      checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL single_ack[%0d]: m1=%b m0=%b want 1/0", i, m1_ack, m0_ack); end
      checks++; if (grant !== 2'b10 || s_dat_ms !== m1_dat_ms) begin errors++; $display("FAIL single_grant[%0d]: grant=%b dat=%0h want 10/%0h", i, grant, s_dat_ms, m1_dat_ms); end
      tick();
    end
    idle_all(); tick();
  endtask

  task automatic test_tie();
    idle_all(); tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_wait: got %b want 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_g0: got %b want 01", grant); end
    tick(); tick();
    m0_cyc = 0; m0_stb = 0; #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_hold: got %b want 01", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_g1: got %b want 10", grant); end
    idle_all(); tick();
  endtask

  task automatic test_preempt();
    int run, prev;
    idle_all(); tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    tick();
    run = 0; prev = -1;
    for (int c = 0; c < 24; c++) begin
      s_dat_sm = $urandom; #1;
      checks++; if (grant !== exp_grant()) begin errors++; $display("FAIL preempt_grant[%0d]: got %b want %b", c, grant, exp_grant()); end
      checks++; if ((m0_ack ^ m1_ack) !== 1'b1 || m0_ack !== (mdl_owner == 0)) begin errors++; $display("FAIL preempt_ack[%0d]: m0=%b m1=%b want owner %0d", c, m0_ack, m1_ack, mdl_owner); end
      if (prev == int'(m1_ack)) run++;
      else begin
        if (prev >= 0) begin
          checks++; if (run != MB) begin errors++; $display("FAIL preempt_run[%0d]: got %0d want %0d", c, run, MB); end
        end
        run = 1; prev = int'(m1_ack);
      end
      if (m0_ack) m0_adr = m0_adr + 4;
      if (m1_ack) m1_adr = m1_adr + 4;
      tick();
    end
    idle_all(); tick();
  endtask

  task automatic test_slow_slave();
    idle_all(); tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    tick();
    m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < MB - 1; i++) begin
      s_ack = 1; #1;
      checks++; if (grant !== 2'b01 || m0_ack !== 1'b1) begin errors++; $display("FAIL slow_pre[%0d]: grant=%b ack=%b want 01/1", i, grant, m0_ack); end
      tick(); m0_adr = m0_adr + 4;
    end
    s_ack = 0;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++; if (grant !== 2'b01 || s_adr !== 32'h100 + 32'(4 * (MB - 1)) || m1_ack !== 1'b0) begin
        errors++; $display("FAIL slow_wait[%0d]: grant=%b adr=%0h m1_ack=%b", w, grant, s_adr, m1_ack);
      end
      tick();
    end
    s_ack = 1; #1;
    checks++; if (grant !== 2'b01 || m0_ack !== 1'b1) begin errors++; $display("FAIL slow_last: grant=%b ack=%b want 01/1", grant, m0_ack); end
    tick(); s_ack = 0; #1;
    checks++; if (grant !== 2'b10 || m0_ack !== 1'b0) begin errors++; $display("FAIL slow_switch: grant=%b m0_ack=%b want 10/0", grant, m0_ack); end
    idle_all(); tick(); tick();
  endtask

  task automatic test_random();
    logic          ec, es, ew, ea0, ea1;
    logic [AW-1:0] ea;
    logic [3:0]    esel;
    for (int c = 0; c < 3000; c++) begin
      m0_cyc = m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      m1_cyc = m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      m0_stb = m0_cyc & $urandom_range(1); m1_stb = m1_cyc & $urandom_range(1);
      m0_we = $urandom_range(1); m1_we = $urandom_range(1);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat_ms = $urandom; m1_dat_ms = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      s_ack = $urandom_range(1); s_dat_sm = $urandom;
      ec = 0; es = 0; ew = 0; ea = '0; esel = '0; ea0 = 0; ea1 = 0;
      if (mdl_owner == 0) begin ec = m0_cyc; es = m0_stb; ew = m0_we; ea = m0_adr; esel = m0_sel; ea0 = s_ack; end
      if (mdl_owner == 1) begin ec = m1_cyc; es = m1_stb; ew = m1_we; ea = m1_adr; esel = m1_sel; ea1 = s_ack; end
      #1;
      checks++; if (grant !== exp_grant()) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, grant, exp_grant()); end
      checks++; if ({s_cyc, s_stb, s_we} !== {ec, es, ew}) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b want %b", c, {s_cyc, s_stb, s_we}, {ec, es, ew}); end
      checks++; if (s_adr !== ea || s_sel !== esel) begin errors++; $display("FAIL rnd_adr[%0d]: got %0h/%h want %0h/%h", c, s_adr, s_sel, ea, esel); end
      checks++; if (m0_ack !== ea0 || m1_ack !== ea1) begin errors++; $display("FAIL rnd_ack[%0d]: got %b%b want %b%b", c, m0_ack, m1_ack, ea0, ea1); end
      checks++; if (m0_dat_sm !== s_dat_sm || m1_dat_sm !== s_dat_sm) begin errors++; $display("FAIL rnd_dat_sm[%0d]: got %0h/%0h want %0h", c, m0_dat_sm, m1_dat_sm, s_dat_sm); end
      if (mdl_owner >= 0) begin
        checks++; if (s_dat_ms !== ((mdl_owner == 0) ? m0_dat_ms : m1_dat_ms)) begin errors++; $display("FAIL rnd_dat_ms[%0d]: got %0h", c, s_dat_ms); end
      end
`ifdef WSHB_ARB_STATS_EN
      checks++; if (m0_ack_cnt !== 32'(e_m0_acks) || m1_ack_cnt !== 32'(e_m1_acks) || preempt_cnt !== 16'(e_pre)) begin
        errors++; $display("FAIL rnd_stats[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", c, m0_ack_cnt, m1_ack_cnt, preempt_cnt, e_m0_acks, e_m1_acks, e_pre);
      end
`endif
      tick();
    end
    idle_all(); tick(); tick();
  endtask

`ifdef WSHB_ARB_STATS_EN
  task automatic test_stats();
    idle_all(); rst = 1; model_reset();
    @(negedge clk); rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1;
    for (int i = 0; i < 40; i++) tick();
    s_ack = 0; #1;
    checks++; if (m0_ack_cnt !== 32'd20) begin errors++; $display("FAIL stats_m0: got %0d want 20", m0_ack_cnt); end
    checks++; if (m1_ack_cnt !== 32'd20) begin errors++; $display("FAIL stats_m1: got %0d want 20", m1_ack_cnt); end
    checks++; if (preempt_cnt !== 16'd10) begin errors++; $display("FAIL stats_pre: got %0d want 10", preempt_cnt); end
    idle_all(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_master();
    test_tie();
    test_preempt();
    test_slow_slave();
    test_random();
`ifdef WSHB_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
